// File: rtl/pla_bist_harness.sv
// ----------------------------------------------------------------------------
// pla_bist_harness
//
// Built-in self-test harness for a 25-input, single-output combinational
// function. An LFSR generates stimulus vectors on x. The function's response
// y0 is compacted into a 16-bit MISR (CRC-CCITT polynomial 0x1021). A separate
// counter tallies the sampled ones. When the run ends, the signature is
// compared against a golden value.
//
// Ports
//   clk           in   1  clock, rising edge
//   rst_n         in   1  asynchronous active-low reset
//   start         in   1  begin a run (honoured only in IDLE)
//   abort         in   1  terminate a run (honoured only in RUN)
//   seed          in  25  LFSR start vector (0 is replaced by 1)
//   num_vectors   in  16  vectors per run, latched at start
//   expected_sig  in  16  golden signature
//   y0            in   1  response of the function for the current x
//   x             out 25  stimulus vector, x[0] drives function input x0
//   busy          out  1  high while vectors are being applied
//   done          out  1  one-cycle completion pulse
//   pass          out  1  signature matched expected_sig at completion
//   signature     out 16  MISR contents
//   ones_count    out 16  number of sampled y0 == 1
//   dbg_state     out  2  FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Control semantics: start and abort are level-sampled single-cycle requests.
// There is no ready signal. A request is acted on at the rising edge only if
// the FSM is in the state that accepts it, and it is silently dropped otherwise.
// done is a one-cycle pulse. pass, signature and ones_count stay stable from
// completion (or abort) until the next accepted start.
// ----------------------------------------------------------------------------
module pla_bist_harness (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [24:0] seed,
    input  logic [15:0] num_vectors,
    input  logic [15:0] expected_sig,
    input  logic        y0,
    output logic [24:0] x,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] signature,
    output logic [15:0] ones_count,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [24:0] x_q, x_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] sig_q, sig_d;
    logic [15:0] ones_q, ones_d;
    logic        pass_q, pass_d;

    logic [15:0] sig_next;
    logic [24:0] x_next;

    // MISR step: shift left, fold the feedback polynomial in when the MSB
    // falls out, and inject the response bit at bit 0.
    assign sig_next = {sig_q[14:0], 1'b0}
                    ^ (sig_q[15] ? 16'h1021 : 16'h0000)
                    ^ {15'b0, y0};

    // Stimulus LFSR step: taps at x[24] and x[21].
    assign x_next = {x_q[23:0], x_q[24] ^ x_q[21]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            x_q     <= '0;
            cnt_q   <= '0;
            sig_q   <= '0;
            ones_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            cnt_q   <= cnt_d;
            sig_q   <= sig_d;
            ones_q  <= ones_d;
            pass_q  <= pass_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        cnt_d   = cnt_q;
        sig_d   = sig_q;
        ones_d  = ones_q;
        pass_d  = pass_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    sig_d  = '0;
                    ones_d = '0;
                    cnt_d  = num_vectors;
                    if (num_vectors == 16'd0) begin
                        // An empty run completes at once. The signature stays 0,
                        // so the verdict depends only on the golden value.
                        state_d = DONE;
                        x_d     = '0;
                        pass_d  = (expected_sig == 16'h0000);
                    end else begin
                        state_d = RUN;
                        // An all-zero LFSR state would lock up, so seed 0 is
                        // replaced with 1.
                        x_d     = (seed == 25'd0) ? 25'd1 : seed;
                        pass_d  = 1'b0;
                    end
                end
            end

            RUN: begin
                if (abort) begin
                    // Abort takes priority even on the last vector. The pending
                    // response is not sampled and done is not pulsed.
                    state_d = IDLE;
                    x_d     = '0;
                end else begin
                    sig_d  = sig_next;
                    ones_d = ones_q + {15'b0, y0};
                    cnt_d  = cnt_q - 16'd1;
                    if (cnt_q == 16'd1) begin
                        state_d = DONE;
                        x_d     = '0;
                        pass_d  = (sig_next == expected_sig);
                    end else begin
                        x_d = x_next;
                    end
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
                x_d     = '0;
            end
        endcase
    end

    assign x          = x_q;
    assign busy       = (state_q == RUN);
    assign done       = (state_q == DONE);
    assign pass       = pass_q;
    assign signature  = sig_q;
    assign ones_count = ones_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_pla_bist_harness.sv
// ----------------------------------------------------------------------------
// tb_pla_bist_harness
//
// Directed testbench for pla_bist_harness. Expected values are hand-derived
// from the LFSR/MISR definitions. The function under test is a small
// selectable model: y0 is either constant 1 or x[1].
// ----------------------------------------------------------------------------
module tb_pla_bist_harness;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic [24:0] seed;
    logic [15:0] num_vectors;
    logic [15:0] expected_sig;
    logic        y0;
    logic [24:0] x;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] signature;
    logic [15:0] ones_count;
    logic [1:0]  dbg_state;

    // Function-under-test model: 0 -> constant 1, 1 -> x[1].
    logic        fut_mode;
    assign y0 = fut_mode ? x[1] : 1'b1;

    int errors;
    int checks;

    pla_bist_harness dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .abort        (abort),
        .seed         (seed),
        .num_vectors  (num_vectors),
        .expected_sig (expected_sig),
        .y0           (y0),
        .x            (x),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .signature    (signature),
        .ones_count   (ones_count),
        .dbg_state    (dbg_state)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver tasks
    // Advance one rising edge. Outputs are sampled and inputs driven 1 ns later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input logic [24:0] s, input logic [15:0] n,
                          input logic [15:0] e);
        seed         = s;
        num_vectors  = n;
        expected_sig = e;
        start        = 1'b1;
        tick();
        start        = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        errors       = 0;
        checks       = 0;
        rst_n        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        seed         = '0;
        num_vectors  = '0;
        expected_sig = '0;
        fut_mode     = 1'b0;

        // Reset state
        #12;
        check("rst_x", x, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_sig", signature, 0);
        check("rst_ones", ones_count, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        tick();

        // Single vector, y0 = 1
        fut_mode = 1'b0;
        launch(25'd1, 16'd1, 16'h0001);
        check("t1_x", x, 25'h1);
        check("t1_busy", busy, 1);
        tick();
        check("t1_done", done, 1);
        check("t1_sig", signature, 16'h0001);
        check("t1_ones", ones_count, 1);
        check("t1_pass", pass, 1);
        check("t1_x_clr", x, 0);
        check("t1_busy_lo", busy, 0);
        // A start in DONE must be ignored.
        start = 1'b1;
        tick();
        start = 1'b0;
        check("t1_done_pulse", done, 0);
        check("t1_start_in_done", dbg_state, 0);
        check("t1_pass_hold", pass, 1);
        check("t1_sig_hold", signature, 16'h0001);

        // Three vectors, y0 = x[1]
        fut_mode = 1'b1;
        launch(25'd1, 16'd3, 16'h0002);
        check("t2_pass_clr", pass, 0);
        check("t2_sig_clr", signature, 0);
        check("t2_x0", x, 25'h1);
        tick();
        check("t2_x1", x, 25'h2);
        tick();
        check("t2_x2", x, 25'h4);
        check("t2_busy", busy, 1);
        tick();
        check("t2_done", done, 1);
        check("t2_sig", signature, 16'h0002);
        check("t2_ones", ones_count, 1);
        check("t2_pass", pass, 1);
        tick();

        // Seed 0 is replaced by 1. The signature after two ones is 0003.
        fut_mode = 1'b0;
        launch(25'd0, 16'd2, 16'h0000);
        check("t3_x0", x, 25'h1);
        tick();
        check("t3_x1", x, 25'h2);
        tick();
        check("t3_done", done, 1);
        check("t3_sig", signature, 16'h0003);
        check("t3_ones", ones_count, 2);
        check("t3_pass_mismatch", pass, 0);
        tick();

        // Empty run
        launch(25'd7, 16'd0, 16'h0000);
        check("t4_done", done, 1);
        check("t4_pass", pass, 1);
        check("t4_x", x, 0);
        check("t4_busy", busy, 0);
        check("t4_sig", signature, 0);
        tick();
        launch(25'd7, 16'd0, 16'h0005);
        check("t4b_done", done, 1);
        check("t4b_pass", pass, 0);
        tick();

        // 100 vectors, abort while vector 40 is presented; a start during RUN is ignored
        fut_mode = 1'b0;
        launch(25'd1, 16'd100, 16'h0000);
        for (int i = 1; i < 40; i++) begin
            if (i == 10) start = 1'b1;
            tick();
            start = 1'b0;
        end
        check("t5_busy_pre", busy, 1);
        check("t5_ones_pre", ones_count, 39);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t5_busy", busy, 0);
        check("t5_x", x, 0);
        check("t5_done", done, 0);
        check("t5_ones", ones_count, 39);
        check("t5_state", dbg_state, 0);
        tick();
        check("t5_done_later", done, 0);
        check("t5_ones_hold", ones_count, 39);

        // Abort on the edge of the last vector: abort wins
        launch(25'd1, 16'd2, 16'h0000);
        tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t6_done", done, 0);
        check("t6_busy", busy, 0);
        check("t6_ones", ones_count, 1);
        check("t6_sig", signature, 16'h0001);
        tick();
        check("t6_done_later", done, 0);

        // Asynchronous reset mid-run, then restart from seed
        launch(25'd1, 16'd100, 16'h0000);
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        check("t7_x", x, 0);
        check("t7_busy", busy, 0);
        check("t7_sig", signature, 0);
        check("t7_ones", ones_count, 0);
        check("t7_pass", pass, 0);
        check("t7_done", done, 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("t7_idle", dbg_state, 0);
        launch(25'h5, 16'd1, 16'h0001);
        check("t7_restart_x", x, 25'h5);
        tick();
        check("t7_restart_done", done, 1);
        check("t7_restart_sig", signature, 16'h0001);
        check("t7_restart_pass", pass, 1);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
